// File: rtl/reset_seq_pkg.sv
// Purpose: shared state codes and timer-width helper for the reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reset_seq_pkg;

    // State encoding is visible on SEQ_STATE, so the codes are fixed.
    localparam logic [2:0] CODE_IDLE    = 3'd0;
    localparam logic [2:0] CODE_QUALIFY = 3'd1;
    localparam logic [2:0] CODE_RELEASE = 3'd2;
    localparam logic [2:0] CODE_RUN     = 3'd3;
    localparam logic [2:0] CODE_HOLD    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = CODE_IDLE,
        ST_QUALIFY = CODE_QUALIFY,
        ST_RELEASE = CODE_RELEASE,
        ST_RUN     = CODE_RUN,
        ST_HOLD    = CODE_HOLD
    } seq_state_e;

    // Width of the shared timer: wide enough to hold the largest terminal
    // count of the three timed phases, plus one bit of margin.
    function automatic int cnt_width(input int qual_cycles,
                                     input int stage_gap,
                                     input int hold_cycles);
        int m;
        m = qual_cycles;
        if (stage_gap > m)   m = stage_gap;
        if (hold_cycles > m) m = hold_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Purpose: two-flop synchroniser for a single asynchronous level.
// Latency: 2 clock edges from input change to sync_out.
// Backpressure: none; free-running level path.
//
// Ports:
//   clk       sampling clock
//   rst       asynchronous active-high reset, both flops clear to 0
//   async_in  level from another clock domain
//   sync_out  synchronised level
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Purpose: qualify clock stability, then release per-subsystem resets LSB first.
// Latency: QUAL_CYCLES after sync, then STAGE_GAP per stage; lock loss reasserts 3 edges after input fall.
// Backpressure: none; SOFT_RESET_REQ_H is honoured only in RUN and never queued.
//
// Ports:
//   CLK_80MHz         sole clock
//   RESET_H           asynchronous active-high reset
//   CLOCKS_STABLE_H   clock-generator stable flag (asynchronous, synchronised here)
//   SOFT_RESET_REQ_H  single-cycle soft-reset request, acted on only in RUN
//   STAGE_RESET_H     per-stage active-high resets, bit 0 released first
//   SEQ_DONE_H        high while in RUN
//   SEQ_STATE         current state code (IDLE=0 .. HOLD=4)
//   LOCK_LOSS_COUNT   saturating count of stability losses outside IDLE
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int QUAL_CYCLES = 1024,
    parameter int STAGE_GAP   = 16,
    parameter int HOLD_CYCLES = 32
) (
    input  logic                  CLK_80MHz,
    input  logic                  RESET_H,
    input  logic                  CLOCKS_STABLE_H,
    input  logic                  SOFT_RESET_REQ_H,
    output logic [NUM_STAGES-1:0] STAGE_RESET_H,
    output logic                  SEQ_DONE_H,
    output logic [2:0]            SEQ_STATE,
    output logic [7:0]            LOCK_LOSS_COUNT
);

    localparam int CNT_W = cnt_width(QUAL_CYCLES, STAGE_GAP, HOLD_CYCLES);
    // Stage index runs 1..NUM_STAGES: the next bit to release, or NUM_STAGES
    // once every bit is out and only the final gap to RUN remains.
    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(QUAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [NUM_STAGES-1:0] ALL_ASSERTED = {NUM_STAGES{1'b1}};
    // Mask after the first release: only bit 0 cleared.
    localparam logic [NUM_STAGES-1:0] FIRST_OUT    = ALL_ASSERTED << 1;
    localparam logic [IDX_W-1:0]      IDX_FIRST    = IDX_W'(1);
    localparam logic [IDX_W-1:0]      IDX_END      = IDX_W'(NUM_STAGES);

    logic                  stable_s;
    seq_state_e            state;
    logic [CNT_W-1:0]      timer;
    logic [IDX_W-1:0]      stage_idx;
    logic [NUM_STAGES-1:0] stage_reset;
    logic                  seq_done;
    logic [7:0]            lock_cnt;
    logic                  active;
    logic                  lock_loss;

    sync_2ff u_stable_sync (
        .clk      (CLK_80MHz),
        .rst      (RESET_H),
        .async_in (CLOCKS_STABLE_H),
        .sync_out (stable_s)
    );

    // Lock loss is only meaningful once the sequencer has left IDLE; the
    // unused codes 5-7 behave as IDLE and so never count a loss.
    always_comb begin
        active = 1'b0;
        case (state)
            ST_QUALIFY, ST_RELEASE, ST_RUN, ST_HOLD: active = 1'b1;
            default:                                 active = 1'b0;
        endcase
        lock_loss = active && !stable_s;
    end

    always_ff @(posedge CLK_80MHz or posedge RESET_H) begin
        if (RESET_H) begin
            state       <= ST_IDLE;
            timer       <= '0;
            stage_idx   <= '0;
            stage_reset <= ALL_ASSERTED;
            seq_done    <= 1'b0;
            lock_cnt    <= 8'd0;
        end else if (lock_loss) begin
            // Highest priority: drop everything back to IDLE in one edge.
            state       <= ST_IDLE;
            timer       <= '0;
            stage_idx   <= '0;
            stage_reset <= ALL_ASSERTED;
            seq_done    <= 1'b0;
            if (lock_cnt != 8'hFF) begin
                lock_cnt <= lock_cnt + 8'd1;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    timer       <= '0;
                    stage_idx   <= '0;
                    stage_reset <= ALL_ASSERTED;
                    seq_done    <= 1'b0;
                    if (stable_s) begin
                        state <= ST_QUALIFY;
                    end
                end

                ST_QUALIFY: begin
                    if (timer == QUAL_LAST) begin
                        state       <= ST_RELEASE;
                        timer       <= '0;
                        stage_idx   <= IDX_FIRST;
                        stage_reset <= FIRST_OUT;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        if (stage_idx == IDX_END) begin
                            state    <= ST_RUN;
                            seq_done <= 1'b1;
                        end else begin
                            // Bits go out strictly LSB first, so shifting in a
                            // zero releases exactly the next stage.
                            stage_reset <= stage_reset << 1;
                            stage_idx   <= stage_idx + IDX_W'(1);
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    timer <= '0;
                    if (SOFT_RESET_REQ_H) begin
                        state       <= ST_HOLD;
                        stage_reset <= ALL_ASSERTED;
                        stage_idx   <= '0;
                        seq_done    <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    // Clocks are still known good here, so requalification
                    // is skipped and release restarts directly.
                    if (timer == HOLD_LAST) begin
                        state       <= ST_RELEASE;
                        timer       <= '0;
                        stage_idx   <= IDX_FIRST;
                        stage_reset <= FIRST_OUT;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    timer       <= '0;
                    stage_idx   <= '0;
                    stage_reset <= ALL_ASSERTED;
                    seq_done    <= 1'b0;
                end
            endcase
        end
    end

    assign STAGE_RESET_H   = stage_reset;
    assign SEQ_DONE_H      = seq_done;
    assign SEQ_STATE       = state;
    assign LOCK_LOSS_COUNT = lock_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose: scoreboard bench for reset_sequencer (4 stages, qual 8, gap 4, hold 6).
// Latency: expectations are keyed to absolute edge numbers after reset release.
// Backpressure: n/a.
module tb_reset_sequencer;

    logic       CLK_80MHz = 1'b0;
    logic       RESET_H;
    logic       CLOCKS_STABLE_H;
    logic       SOFT_RESET_REQ_H;
    logic [3:0] STAGE_RESET_H;
    logic       SEQ_DONE_H;
    logic [2:0] SEQ_STATE;
    logic [7:0] LOCK_LOSS_COUNT;

    logic clk_run = 1'b1;
    always #5 if (clk_run) CLK_80MHz = ~CLK_80MHz;

    reset_sequencer #(
        .NUM_STAGES  (4),
        .QUAL_CYCLES (8),
        .STAGE_GAP   (4),
        .HOLD_CYCLES (6)
    ) dut (
        .CLK_80MHz        (CLK_80MHz),
        .RESET_H          (RESET_H),
        .CLOCKS_STABLE_H  (CLOCKS_STABLE_H),
        .SOFT_RESET_REQ_H (SOFT_RESET_REQ_H),
        .STAGE_RESET_H    (STAGE_RESET_H),
        .SEQ_DONE_H       (SEQ_DONE_H),
        .SEQ_STATE        (SEQ_STATE),
        .LOCK_LOSS_COUNT  (LOCK_LOSS_COUNT)
    );

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_QUAL = 3'd1;
    localparam logic [2:0] S_REL  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    typedef struct packed {
        int unsigned e;
        logic [3:0]  stg;
        logic        done;
        logic [2:0]  st;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    string       tag_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Edge counter: edge n is the nth rising edge after RESET_H falls.
    always @(posedge CLK_80MHz) begin
        if (!RESET_H) cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_at(input int unsigned e, input logic [3:0] stg, input logic done,
                             input logic [2:0] st, input logic [7:0] cnt, input string tag);
        exp_t x;
        x.e    = e;
        x.stg  = stg;
        x.done = done;
        x.st   = st;
        x.cnt  = cnt;
        sb_q.push_back(x);
        tag_q.push_back(tag);
    endtask

    // Full qualify-and-release sequence when the stable input rises after edge c.
    task automatic expect_powerup(input int unsigned c, input logic [7:0] cnt);
        expect_at(c + 2,  4'hF, 1'b0, S_IDLE, cnt, "pu_idle");
        expect_at(c + 3,  4'hF, 1'b0, S_QUAL, cnt, "pu_qual");
        expect_at(c + 10, 4'hF, 1'b0, S_QUAL, cnt, "pu_qual_last");
        expect_at(c + 11, 4'hE, 1'b0, S_REL,  cnt, "pu_rel0");
        expect_at(c + 14, 4'hE, 1'b0, S_REL,  cnt, "pu_rel0_hold");
        expect_at(c + 15, 4'hC, 1'b0, S_REL,  cnt, "pu_rel1");
        expect_at(c + 18, 4'hC, 1'b0, S_REL,  cnt, "pu_rel1_hold");
        expect_at(c + 19, 4'h8, 1'b0, S_REL,  cnt, "pu_rel2");
        expect_at(c + 23, 4'h0, 1'b0, S_REL,  cnt, "pu_rel3");
        expect_at(c + 26, 4'h0, 1'b0, S_REL,  cnt, "pu_pre_run");
        expect_at(c + 27, 4'h0, 1'b1, S_RUN,  cnt, "pu_run");
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge CLK_80MHz);
    endtask

    function automatic logic [7:0] sat(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    // Scoreboard drain: compare every expectation whose edge has arrived.
    always @(negedge CLK_80MHz) begin
        while (sb_q.size() > 0 && sb_q[0].e <= cyc) begin
            exp_t  x;
            string t;
            x = sb_q.pop_front();
            t = tag_q.pop_front();
            if (x.e < cyc) begin
                chk({t, ".missed"}, 32'(cyc), 32'(x.e));
            end else begin
                chk({t, ".stage"}, 32'(STAGE_RESET_H),   32'(x.stg));
                chk({t, ".done"},  32'(SEQ_DONE_H),      32'(x.done));
                chk({t, ".state"}, 32'(SEQ_STATE),       32'(x.st));
                chk({t, ".count"}, 32'(LOCK_LOSS_COUNT), 32'(x.cnt));
            end
        end
    end

    initial begin
        int unsigned c;

        RESET_H          = 1'b1;
        CLOCKS_STABLE_H  = 1'b1;
        SOFT_RESET_REQ_H = 1'b0;

        // Reset values must appear before any clock edge.
        #1;
        chk("rst0.stage", 32'(STAGE_RESET_H),   32'hF);
        chk("rst0.done",  32'(SEQ_DONE_H),      32'h0);
        chk("rst0.state", 32'(SEQ_STATE),       32'(S_IDLE));
        chk("rst0.count", 32'(LOCK_LOSS_COUNT), 32'h0);

        repeat (3) @(negedge CLK_80MHz);
        RESET_H = 1'b0;

        // Power-up with the stable flag already high.
        expect_powerup(0, 8'd0);
        expect_at(30, 4'h0, 1'b1, S_RUN, 8'd0, "run_steady");
        wait_until(30);

        // Lock loss in RUN: reasserted exactly 3 edges after the fall.
        expect_at(32, 4'h0, 1'b1, S_RUN,  8'd0, "ll_run_pre");
        expect_at(33, 4'hF, 1'b0, S_IDLE, 8'd1, "ll_run");
        expect_at(34, 4'hF, 1'b0, S_IDLE, 8'd1, "ll_run_idle");
        CLOCKS_STABLE_H = 1'b0;
        wait_until(35);

        // Requalify, then a one-cycle glitch mid-QUALIFY.
        expect_at(37, 4'hF, 1'b0, S_IDLE, 8'd1, "rq_idle");
        expect_at(38, 4'hF, 1'b0, S_QUAL, 8'd1, "rq_qual");
        expect_at(43, 4'hF, 1'b0, S_QUAL, 8'd1, "rq_pre_glitch");
        CLOCKS_STABLE_H = 1'b1;
        wait_until(41);
        CLOCKS_STABLE_H = 1'b0;
        wait_until(42);
        CLOCKS_STABLE_H = 1'b1;
        expect_powerup(42, 8'd2);
        wait_until(70);

        // Soft reset in RUN, then an ignored pulse during RELEASE.
        expect_at(72, 4'h0, 1'b1, S_RUN,  8'd2, "sr_pre");
        expect_at(73, 4'hF, 1'b0, S_HOLD, 8'd2, "sr_hold");
        expect_at(78, 4'hF, 1'b0, S_HOLD, 8'd2, "sr_hold_last");
        expect_at(79, 4'hE, 1'b0, S_REL,  8'd2, "sr_rel0");
        expect_at(83, 4'hC, 1'b0, S_REL,  8'd2, "sr_rel1");
        expect_at(85, 4'hC, 1'b0, S_REL,  8'd2, "sr_ignored");
        expect_at(87, 4'h8, 1'b0, S_REL,  8'd2, "sr_rel2");
        expect_at(91, 4'h0, 1'b0, S_REL,  8'd2, "sr_rel3");
        expect_at(94, 4'h0, 1'b0, S_REL,  8'd2, "sr_pre_run");
        expect_at(95, 4'h0, 1'b1, S_RUN,  8'd2, "sr_run");
        wait_until(72);
        SOFT_RESET_REQ_H = 1'b1;
        wait_until(73);
        SOFT_RESET_REQ_H = 1'b0;
        wait_until(84);
        SOFT_RESET_REQ_H = 1'b1;
        wait_until(85);
        SOFT_RESET_REQ_H = 1'b0;
        wait_until(97);

        // Soft request and lock loss on the same edge: lock loss wins.
        expect_at(102, 4'h0, 1'b1, S_RUN,  8'd2, "both_pre");
        expect_at(103, 4'hF, 1'b0, S_IDLE, 8'd3, "both");
        expect_at(104, 4'hF, 1'b0, S_IDLE, 8'd3, "both_idle");
        wait_until(100);
        CLOCKS_STABLE_H = 1'b0;
        wait_until(102);
        SOFT_RESET_REQ_H = 1'b1;
        wait_until(103);
        SOFT_RESET_REQ_H = 1'b0;
        wait_until(105);

        // 300 further losses: the counter must stop at 255.
        c = 105;
        for (int i = 0; i < 300; i++) begin
            CLOCKS_STABLE_H = 1'b1;
            expect_at(c + 3, 4'hF, 1'b0, S_QUAL, sat(3 + i), "sat_qual");
            expect_at(c + 6, 4'hF, 1'b0, S_IDLE, sat(4 + i), "sat_loss");
            wait_until(c + 3);
            CLOCKS_STABLE_H = 1'b0;
            wait_until(c + 6);
            c = c + 6;
        end

        // Async reset mid-RELEASE with the clock stopped.
        CLOCKS_STABLE_H = 1'b1;
        expect_at(c + 2,  4'hF, 1'b0, S_IDLE, 8'd255, "ar_idle");
        expect_at(c + 3,  4'hF, 1'b0, S_QUAL, 8'd255, "ar_qual");
        expect_at(c + 11, 4'hE, 1'b0, S_REL,  8'd255, "ar_rel0");
        expect_at(c + 15, 4'hC, 1'b0, S_REL,  8'd255, "ar_rel1");
        wait_until(c + 16);
        clk_run = 1'b0;
        #3;
        RESET_H = 1'b1;
        #1;
        chk("arst.stage", 32'(STAGE_RESET_H),   32'hF);
        chk("arst.done",  32'(SEQ_DONE_H),      32'h0);
        chk("arst.state", 32'(SEQ_STATE),       32'(S_IDLE));
        chk("arst.count", 32'(LOCK_LOSS_COUNT), 32'h0);
        chk("sb_drained", 32'(sb_q.size()),     32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
